// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time
// instruction loader.
package loader_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 19;

  localparam logic [7:0] H0_RSV_MASK = 8'hF0;
  localparam logic [7:0] B0_RSV_MASK = 8'hF8;

  typedef enum logic [2:0] {
    S_H0,
    S_H1,
    S_B0,
    S_B1,
    S_B2,
    S_CK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs three stream bytes into one 19-bit
// instruction word and flags reserved-bit misuse.
module instr_word_assembler
  import loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic [1:0]             pos,
  input  logic                   load,
  output logic [INSTR_W_DEF-1:0] word,
  output logic                   viol
);

  logic [INSTR_W_DEF-1:0] word_q;
  logic [INSTR_W_DEF-1:0] word_d;

  assign viol = (pos == 2'd0) &&
                (|(byte_in & B0_RSV_MASK));
  assign word = word_q;

  always_comb begin
    word_d = word_q;
    if (load) begin
      unique case (pos)
        2'd0:    word_d[18:16] = byte_in[2:0];
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[7:0]   = byte_in;
        default: word_d        = word_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

endmodule

// File: rtl/instr_loader.sv
// Frames a byte stream into instruction-memory
// writes and releases the datapath when verified.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [7:0]  xor_q, xor_d;
  logic        im_we_q, im_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [1:0]  asm_pos;
  logic        asm_load;
  logic        asm_viol;
  logic [INSTR_W_DEF-1:0] asm_word;
  logic [11:0] wcnt_inc;
  logic [11:0] hdr_count;

  assign in_ready = !rst &&
                    (state_q != S_DONE) &&
                    (state_q != S_ERR);
  assign xfer = in_valid && in_ready;

  assign wcnt_inc  = wcnt_q + 12'd1;
  assign hdr_count = {count_q[11:8], in_data};

  always_comb begin
    asm_pos = 2'd0;
    unique case (state_q)
      S_B1:    asm_pos = 2'd1;
      S_B2:    asm_pos = 2'd2;
      default: asm_pos = 2'd0;
    endcase
  end

  // A malformed B0 must not disturb the word reg.
  assign asm_load = xfer && !asm_viol &&
                    ((state_q == S_B0) ||
                     (state_q == S_B1) ||
                     (state_q == S_B2));

  instr_word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .byte_in (in_data),
    .pos     (asm_pos),
    .load    (asm_load),
    .word    (asm_word),
    .viol    (asm_viol)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wcnt_d    = wcnt_q;
    xor_d     = xor_q;
    im_we_d   = 1'b0;
    addr_d    = addr_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;

    if (im_we_q) addr_d = addr_q + 1'b1;

    if (xfer) begin
      xor_d = xor_q ^ in_data;
      unique case (state_q)
        S_H0: begin
          if (|(in_data & H0_RSV_MASK)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            count_d[11:8] = in_data[3:0];
            state_d       = S_H1;
          end
        end
        S_H1: begin
          count_d[7:0] = in_data;
          state_d = (hdr_count == 12'd0) ?
                    S_CK : S_B0;
        end
        S_B0: begin
          if (asm_viol) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_B1;
          end
        end
        S_B1: state_d = S_B2;
        S_B2: begin
          im_we_d = 1'b1;
          wcnt_d  = wcnt_inc;
          state_d = (wcnt_inc == count_q) ?
                    S_CK : S_B0;
        end
        S_CK: begin
          if (in_data == xor_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_H0;
      count_q   <= '0;
      wcnt_q    <= '0;
      xor_q     <= '0;
      im_we_q   <= 1'b0;
      addr_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wcnt_q    <= wcnt_d;
      xor_q     <= xor_d;
      im_we_q   <= im_we_d;
      addr_q    <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = addr_q;
  assign im_wdata = INSTR_W'(asm_word);
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: framing,
// checksum, gaps and mid-frame reset.
module tb_instr_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [11:0] im_addr;
  logic [18:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [18:0] mem [4096];
  logic [11:0] wa_q [$];
  logic [18:0] wd_q [$];
  logic [7:0]  seq [$];

  instr_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && im_we) begin
      mem[im_addr] = im_wdata;
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rdy_in_rst", 32'(in_ready), 0);
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit gaps);
    int n = 0;
    if (gaps) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL tx_timeout got=0 exp=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i], 1'b0);
  endtask

  task automatic good_head(input bit gaps);
    send_byte(8'h00, gaps);
    send_byte(8'h02, gaps);
    send_byte(8'h01, gaps);
    send_byte(8'h23, gaps);
    send_byte(8'h45, gaps);
    chk("we0", 32'(im_we), 1);
    chk("addr0", 32'(im_addr), 0);
    chk("wd0", 32'(im_wdata), 32'h12345);
  endtask

  task automatic good_tail(input bit gaps);
    send_byte(8'h07, gaps);
    send_byte(8'hFF, gaps);
    send_byte(8'hFF, gaps);
    chk("we1", 32'(im_we), 1);
    chk("addr1", 32'(im_addr), 1);
    chk("wd1", 32'(im_wdata), 32'h7FFFF);
    chk("crst_pre", 32'(cpu_rst), 1);
    send_byte(8'h62, gaps);
  endtask

  task automatic good_final(input string t);
    chk({t, "_nwr"}, 32'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      chk({t, "_wa0"}, 32'(wa_q[0]), 0);
      chk({t, "_wa1"}, 32'(wa_q[1]), 1);
    end
    chk({t, "_m0"}, 32'(mem[0]), 32'h12345);
    chk({t, "_m1"}, 32'(mem[1]), 32'h7FFFF);
    chk({t, "_done"}, 32'(done), 1);
    chk({t, "_crst"}, 32'(cpu_rst), 0);
    chk({t, "_err"}, 32'(err), 0);
    chk({t, "_rdy"}, 32'(in_ready), 0);
  endtask

  initial begin
    do_reset();
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_we", 32'(im_we), 0);
    chk("rst_addr", 32'(im_addr), 0);
    chk("rst_wd", 32'(im_wdata), 0);
    chk("rst_crst", 32'(cpu_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    good_head(1'b0);
    good_tail(1'b0);
    good_final("t1");

    do_reset();
    seq = '{8'h00, 8'h02, 8'h01, 8'h23,
            8'h45, 8'h07, 8'hFF, 8'hFF};
    send_seq(seq);
    send_byte(8'h63, 1'b0);
    chk("ck_nwr", 32'(wa_q.size()), 2);
    chk("ck_err", 32'(err), 1);
    chk("ck_done", 32'(done), 0);
    chk("ck_crst", 32'(cpu_rst), 1);
    chk("ck_rdy", 32'(in_ready), 0);

    do_reset();
    seq = '{8'h00, 8'h01};
    send_seq(seq);
    chk("b0_err_pre", 32'(err), 0);
    send_byte(8'h08, 1'b0);
    chk("b0_err", 32'(err), 1);
    chk("b0_rdy", 32'(in_ready), 0);
    chk("b0_crst", 32'(cpu_rst), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("b0_nwr", 32'(wa_q.size()), 0);

    do_reset();
    send_byte(8'h10, 1'b0);
    chk("h0_err", 32'(err), 1);
    chk("h0_done", 32'(done), 0);

    do_reset();
    seq = '{8'h00, 8'h00};
    send_seq(seq);
    chk("z_done_pre", 32'(done), 0);
    send_byte(8'h00, 1'b0);
    chk("z_done", 32'(done), 1);
    chk("z_crst", 32'(cpu_rst), 0);
    chk("z_nwr", 32'(wa_q.size()), 0);

    do_reset();
    good_head(1'b1);
    good_tail(1'b1);
    good_final("gap");

    do_reset();
    mem[0] = '0;
    mem[1] = '0;
    good_head(1'b0);
    @(posedge clk);
    #1;
    chk("mr_addr_inc", 32'(im_addr), 1);
    do_reset();
    chk("mr_addr_rst", 32'(im_addr), 0);
    chk("mr_keep", 32'(mem[0]), 32'h12345);
    good_head(1'b0);
    good_tail(1'b0);
    good_final("mr");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
